// File: rtl/kernel_sequencer_if.sv
// Job/config handshake and per-cycle control outputs of the kernel sequencer.
// master drives jobs in; slave is the sequencer.
interface kernel_sequencer_if #(
    parameter int unsigned CTRL_WIDTH = 9,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LEN_WIDTH  = 8
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  cfg_len;
    logic [LEN_WIDTH-1:0]  cfg_count;
    logic [ADDR_WIDTH-1:0] cfg_base;
    logic                  stall;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  busy;
    logic                  done;

    modport master (
        output start, cfg_len, cfg_count, cfg_base, stall,
        input  ctrl, rd_en, rd_addr, busy, done
    );

    modport slave (
        input  start, cfg_len, cfg_count, cfg_base, stall,
        output ctrl, rd_en, rd_addr, busy, done
    );
endinterface

// File: rtl/kernel_sequencer.sv
// Issues cfg_len*cfg_count operand reads as per-cycle MAC control words, then
// waits DRAIN_CYCLES for the datapath to settle and pulses done.
module kernel_sequencer #(
    parameter int unsigned CTRL_WIDTH   = 9,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned LEN_WIDTH    = 8,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input logic               clk,
    input logic               rst,
    kernel_sequencer_if.slave bus
);
    localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DrainW-1:0] DrainLast =
        (DRAIN_CYCLES > 0) ? DrainW'(DRAIN_CYCLES - 1) : '0;
    localparam int unsigned BitValid = 0;
    localparam int unsigned BitLast  = 7;
    localparam int unsigned BitFirst = 8;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic [LEN_WIDTH-1:0]  elem_q, elem_d;
    logic [LEN_WIDTH-1:0]  kern_q, kern_d;
    logic [DrainW-1:0]     drain_q, drain_d;
    logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  issue, first, last;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q;
        elem_d    = elem_q;
        kern_d    = kern_q;
        drain_d   = drain_q;
        rd_addr_d = rd_addr_q;
        ctrl_d    = '0;
        done_d    = 1'b0;
        issue     = 1'b0;
        first     = 1'b0;
        last      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // busy_q still covers the done cycle, so a start there is dropped
                if (bus.start && !busy_q) begin
                    len_d   = bus.cfg_len;
                    count_d = bus.cfg_count;
                    elem_d  = '0;
                    kern_d  = '0;
                    drain_d = '0;
                    if (bus.cfg_len == '0 || bus.cfg_count == '0) begin
                        state_d = StFin;
                    end else begin
                        issue     = 1'b1;
                        first     = 1'b1;
                        last      = (bus.cfg_len == LEN_WIDTH'(1));
                        rd_addr_d = bus.cfg_base;
                        state_d   = (last && bus.cfg_count == LEN_WIDTH'(1)) ? StDrain : StRun;
                    end
                end
            end
            StRun: begin
                if (!bus.stall) begin
                    issue     = 1'b1;
                    rd_addr_d = rd_addr_q + 1'b1;
                    if (elem_q == len_q - 1'b1) begin
                        elem_d = '0;
                        kern_d = kern_q + 1'b1;
                    end else begin
                        elem_d = elem_q + 1'b1;
                    end
                    first = (elem_d == '0);
                    last  = (elem_d == len_q - 1'b1);
                    if (last && kern_d == count_q - 1'b1) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    state_d = StFin;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        ctrl_d[BitValid] = issue;
        ctrl_d[BitFirst] = issue && first;
        ctrl_d[BitLast]  = issue && last;
        rd_en_d          = issue;
        busy_d           = (state_d != StIdle) || (state_q == StFin);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            len_q     <= '0;
            count_q   <= '0;
            elem_q    <= '0;
            kern_q    <= '0;
            drain_q   <= '0;
            ctrl_q    <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            count_q   <= count_d;
            elem_q    <= elem_d;
            kern_q    <= kern_d;
            drain_q   <= drain_d;
            ctrl_q    <= ctrl_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.ctrl    = ctrl_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_kernel_sequencer.sv
// Bench for kernel_sequencer: directed and random jobs checked cycle by cycle
// against a linear-index reference model.
module tb_kernel_sequencer;
    localparam int CW = 9;
    localparam int AW = 10;
    localparam int LW = 8;
    localparam int DC = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kernel_sequencer_if #(.CTRL_WIDTH(CW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    kernel_sequencer #(
        .CTRL_WIDTH(CW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_addr = '0;

    // Runs one job from its start cycle (c=0) until the cycle after done.
    // stall_mode: 0 none, 1 random, 2 high in cycles 2 and 3.
    task automatic run_job(input string tag, input int len, input int cnt,
                           input logic [AW-1:0] base, input int stall_mode, input bit poke);
        int total = len * cnt;
        int next_idx = 0;
        int done_c = (total == 0) ? 2 : -1;
        int budget = total * 4 + 40;
        bit prev_stall = 1'b0;
        bit exp_v;
        bit finished = 1'b0;
        logic [CW-1:0] exp_ctrl;

        bus.cfg_len   = LW'(len);
        bus.cfg_count = LW'(cnt);
        bus.cfg_base  = base;
        bus.start     = 1'b1;
        bus.stall     = (stall_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;

        for (int c = 1; c <= budget && !finished; c++) begin
            @(negedge clk);
            exp_v = (total > 0) &&
                    ((c == 1) || (next_idx > 0 && next_idx < total && !prev_stall));
            exp_ctrl = '0;
            if (exp_v) begin
                exp_addr    = AW'(int'(base) + next_idx);
                exp_ctrl[0] = 1'b1;
                exp_ctrl[8] = (next_idx % len == 0);
                exp_ctrl[7] = (next_idx % len == len - 1);
                next_idx++;
                if (next_idx == total) done_c = c + DC + 1;
            end

            checks++;
            if (bus.ctrl !== exp_ctrl) begin
                errors++;
                $display("FAIL %s ctrl c=%0d got %h want %h", tag, c, bus.ctrl, exp_ctrl);
            end
            checks++;
            if (bus.rd_en !== exp_v) begin
                errors++;
                $display("FAIL %s rd_en c=%0d got %b want %b", tag, c, bus.rd_en, exp_v);
            end
            checks++;
            if (bus.rd_addr !== exp_addr) begin
                errors++;
                $display("FAIL %s rd_addr c=%0d got %h want %h", tag, c, bus.rd_addr, exp_addr);
            end
            checks++;
            if (bus.done !== (c == done_c)) begin
                errors++;
                $display("FAIL %s done c=%0d got %b want %b", tag, c, bus.done, c == done_c);
            end
            checks++;
            if (bus.busy !== (done_c < 0 || c <= done_c)) begin
                errors++;
                $display("FAIL %s busy c=%0d got %b want %b", tag, c, bus.busy,
                         done_c < 0 || c <= done_c);
            end

            if (done_c > 0 && c == done_c + 1) begin
                finished = 1'b1;
                bus.start = 1'b0;
                bus.stall = 1'b0;
            end else begin
                case (stall_mode)
                    1:       bus.stall = ($urandom_range(0, 3) == 0);
                    2:       bus.stall = (c == 2 || c == 3);
                    default: bus.stall = 1'b0;
                endcase
                prev_stall = bus.stall;
                // Extra starts while busy (and on the done cycle) must be dropped
                if (poke && ($urandom_range(0, 1) == 1 || c == done_c)) begin
                    bus.start     = 1'b1;
                    bus.cfg_len   = LW'($urandom_range(1, 9));
                    bus.cfg_count = LW'($urandom_range(1, 9));
                    bus.cfg_base  = AW'($urandom);
                end else begin
                    bus.start = 1'b0;
                end
            end
        end

        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout issued %0d want %0d", tag, next_idx, total);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.cfg_len = 8'd3;
        bus.cfg_count = 8'd3;
        bus.cfg_base = 10'h155;
        bus.stall = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.ctrl, bus.rd_en, bus.rd_addr, bus.busy, bus.done} !== '0) begin
            errors++;
            $display("FAIL reset outputs got ctrl=%h rd_en=%b addr=%h busy=%b done=%b want 0",
                     bus.ctrl, bus.rd_en, bus.rd_addr, bus.busy, bus.done);
        end
        rst = 1'b0;
        bus.start = 1'b0;
        exp_addr = '0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy got %b want 0", bus.busy);
        end
    endtask

    // Abort a job by reset after 'cycles' cycles; expect clean idle and no done.
    task automatic test_reset_abort(input string tag, input int len, input int cnt,
                                    input int cycles);
        bus.cfg_len = LW'(len);
        bus.cfg_count = LW'(cnt);
        bus.cfg_base = 10'h010;
        bus.start = 1'b1;
        bus.stall = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (cycles - 1) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s pre_rst busy got %b want 1", tag, bus.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.ctrl, bus.rd_en, bus.rd_addr, bus.busy, bus.done} !== '0) begin
            errors++;
            $display("FAIL %s post_rst got ctrl=%h rd_en=%b addr=%h busy=%b done=%b want 0",
                     tag, bus.ctrl, bus.rd_en, bus.rd_addr, bus.busy, bus.done);
        end
        rst = 1'b0;
        exp_addr = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL %s aborted_job done=%b busy=%b want 0 0", tag, bus.done, bus.busy);
            end
        end
    endtask

    task automatic test_basic();
        run_job("basic", 3, 2, 10'h010, 0, 1'b0);
    endtask

    task automatic test_stall();
        run_job("stall", 3, 2, 10'h010, 2, 1'b0);
    endtask

    task automatic test_len_one();
        run_job("len1", 1, 4, 10'h123, 0, 1'b0);
    endtask

    task automatic test_wrap();
        run_job("wrap", 4, 1, 10'h3FE, 0, 1'b0);
    endtask

    task automatic test_zero();
        run_job("zero_count", 5, 0, 10'h200, 0, 1'b1);
        run_job("zero_len", 0, 3, 10'h201, 0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_job("b2b_a", 2, 3, 10'h050, 1, 1'b1);
        run_job("b2b_b", 1, 1, 10'h3FF, 1, 1'b1);
        run_job("b2b_c", 5, 2, 10'h0F0, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 30; j++) begin
            run_job("random", int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
                    AW'($urandom), 1, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.cfg_len = '0;
        bus.cfg_count = '0;
        bus.cfg_base = '0;
        bus.stall = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_len_one();
        test_wrap();
        test_zero();
        test_reset_abort("rst_run", 3, 2, 3);
        run_job("after_rst_run", 3, 2, 10'h010, 0, 1'b0);
        test_reset_abort("rst_drain", 1, 1, 3);
        run_job("after_rst_drain", 2, 2, 10'h3FD, 0, 1'b0);
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kernel_sequencer.md
KERNEL_SEQUENCER -- requirements
Module: kernel_sequencer

Interface
REQ-001: Parameter CTRL_WIDTH, default 9, SHALL set the width of the control word driven to the multiply-accumulate datapath.
REQ-002: Parameter ADDR_WIDTH, default 10, SHALL set the operand RAM read-address width.
REQ-003: Parameter LEN_WIDTH, default 8, SHALL set the width of the kernel-length and kernel-count fields.
REQ-004: Parameter DRAIN_CYCLES, default 3, SHALL set the post-issue wait before done, covering RAM read latency plus one accumulate cycle.
REQ-005: clk  input  1  single clock; all state updates on its rising edge.
REQ-006: rst  input  1  synchronous, active-high reset.
REQ-007: start  input  1  single-cycle job request, sampled only in IDLE.
REQ-008: cfg_len  input  LEN_WIDTH  elements per kernel, captured on accepted start.
REQ-009: cfg_count  input  LEN_WIDTH  kernels per job, captured on accepted start.
REQ-010: cfg_base  input  ADDR_WIDTH  first RAM address of the job, captured on accepted start.
REQ-011: stall  input  1  downstream back-pressure; freezes issue while high.
REQ-012: ctrl  output  CTRL_WIDTH  per-cycle control word: bit0 = valid, bit8 = first element of kernel, bit7 = last element of kernel, bits 6:1 = 0.
REQ-013: rd_en  output  1  operand RAM read enable, equal to ctrl[0].
REQ-014: rd_addr  output  ADDR_WIDTH  operand RAM read address.
REQ-015: busy  output  1  high in every state other than IDLE.
REQ-016: done  output  1  one-cycle pulse at job completion.

Function
REQ-017: The FSM SHALL have four states: IDLE, RUN, DRAIN and FIN.
REQ-018: All outputs SHALL be registered.
REQ-019: In IDLE, start=1 SHALL capture cfg_len, cfg_count and cfg_base.
REQ-020: After an accepted start with nonzero cfg_len and nonzero cfg_count, the FSM SHALL enter RUN; the first ctrl valid appears in the cycle after start.
REQ-021: An accepted start with cfg_len=0 or cfg_count=0 SHALL go directly to FIN; no ctrl valid is ever issued for that job.
REQ-022: While busy=1, start SHALL be ignored and configuration SHALL not be recaptured.
REQ-023: In RUN with stall=0, each cycle SHALL issue one element: ctrl[0]=1 and rd_en=1.
REQ-024: For an issued element, rd_addr SHALL equal cfg_base plus the linear element index (kernel_idx*cfg_len + elem_idx), modulo 2^ADDR_WIDTH (wraps silently).
REQ-025: For an issued element, ctrl[8]=1 exactly when elem_idx=0.
REQ-026: For an issued element, ctrl[7]=1 exactly when elem_idx=cfg_len-1.
REQ-027: When cfg_len=1, every issued element SHALL carry both ctrl[8] and ctrl[7].
REQ-028: In RUN with stall=1, the next cycle SHALL have ctrl=0 and rd_en=0, rd_addr SHALL hold, and the element and kernel counters SHALL hold.
REQ-029: Issue SHALL resume with the next unissued element on the first cycle after stall deasserts; no element is skipped or duplicated.
REQ-030: After the last element of the last kernel issues, the FSM SHALL enter DRAIN.
REQ-031: DRAIN SHALL last exactly DRAIN_CYCLES cycles, independent of stall, with ctrl=0 throughout.
REQ-032: After DRAIN, the FSM SHALL enter FIN.
REQ-033: FIN SHALL last one cycle: done=1 and busy=1, then return to IDLE.
REQ-034: A start coincident with the FIN cycle SHALL be ignored.
REQ-035: Total issued valids per job SHALL equal cfg_len*cfg_count (up to 65025).
REQ-036: The element and kernel counters SHALL be LEN_WIDTH wide.

Reset
REQ-037: rst=1 SHALL force IDLE and set ctrl=0, rd_en=0, rd_addr=0, busy=0, done=0 and all counters to 0 on the next edge.
REQ-038: rst SHALL take priority over start, stall and any state, including mid-RUN and mid-DRAIN.
REQ-039: A job aborted by reset SHALL produce no done pulse.

Verification
REQ-040: cfg_len=3, cfg_count=2, cfg_base=0x010, no stall -> 6 valids at addresses 0x010-0x015; ctrl[8] on 0x010 and 0x013; ctrl[7] on 0x012 and 0x015; done exactly 4 cycles after the last valid (3 DRAIN + FIN).
REQ-041: Same job with stall high for 2 cycles after the 2nd valid -> 2 idle ctrl cycles; the sequence resumes at 0x012; identical flag and address sequence otherwise.
REQ-042: cfg_len=1, cfg_count=4 -> 4 valids, each with ctrl[8]=ctrl[7]=1.
REQ-043: cfg_len=4, cfg_count=1, cfg_base=0x3FE -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-044: cfg_count=0 -> no valids; done pulse in the cycle after FIN entry (2 cycles after start); start during busy ignored.
REQ-045: rst asserted during the 3rd valid -> all outputs 0 the next cycle, no done; a new start afterwards runs normally.
